// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU
// Optional MUL_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic [1:0]         op_q;
    logic               neg;

    logic               rs1_neg;
    logic               rs2_neg;
    logic [WIDTH-1:0]   rs1_mag;
    logic [WIDTH-1:0]   rs2_mag;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mplier_step;
    logic               last_step;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   result_next;

    // rs1 is signed for MULH and MULHSU, rs2 only for MULH
    always_comb begin
        rs1_neg = ((op == 2'b01) || (op == 2'b10)) && rs1[WIDTH-1];
        rs2_neg = (op == 2'b01) && rs2[WIDTH-1];
        rs1_mag = rs1_neg ? -rs1 : rs1;
        rs2_mag = rs2_neg ? -rs2 : rs2;
    end

    always_comb begin
        acc_step    = mplier[0] ? acc + mcand : acc;
        mplier_step = mplier >> 1;
`ifdef MUL_EARLY_TERM_EN
        last_step   = (count == LAST_STEP) || (mplier_step == '0);
`else
        last_step   = (count == LAST_STEP);
`endif
        // Sign fix on the final step so result is valid while done is high
        product     = neg ? -acc_step : acc_step;
        result_next = (op_q == 2'b00) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            op_q   <= '0;
            neg    <= 1'b0;
            result <= '0;
        end else if (kill) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_CALC: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier_step;
                    count  <= count + 1'b1;
                    if (last_step) begin
                        state  <= S_DONE;
                        result <= result_next;
                    end
                end
                default: begin
                    if (start) begin
                        state  <= S_CALC;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, rs1_mag};
                        mplier <= rs2_mag;
                        count  <= '0;
                        op_q   <= op;
                        neg    <= rs1_neg ^ rs2_neg;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed and random checks for shift_add_multiplier
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op),
        .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] sa, sb, p;
        sa = ((o == 2'b01) || (o == 2'b10)) ? {{34{a[31]}}, a} : {34'b0, a};
        sb = (o == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
        p  = sa * sb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
        logic [31:0] mag;
        int idx;
        mag = ((o == 2'b01) && b[31]) ? -b : b;
        idx = 0;
        for (int k = 0; k < 32; k++)
            if (mag[k]) idx = k;
        return 2 + idx;
`else
        return 33;
`endif
    endfunction

    // Call at a negedge; returns at the negedge of the first CALC cycle with inputs scrambled
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(negedge clk);
        start = 1'b0; op = ~o; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678;
    endtask

    task automatic wait_done(input string name, output int lat, output int bc);
        lat = 1;
        bc  = 0;
        while (!done && lat < 200) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_vec(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int lat, bc, el;
        el = exp_lat(o, b);
        launch(o, a, b);
        wait_done(name, lat, bc);
        check({name, "_result"}, result, exp);
        check({name, "_latency"}, lat, el);
        check({name, "_busy_cycles"}, bc, el - 1);
        @(negedge clk);
        check({name, "_done_one_cycle"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int lat, bc, total;
        logic done_seen;

        vecs[0]  = '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
        vecs[1]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[3]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[5]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[6]  = '{2'b01, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7]  = '{2'b01, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[8]  = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
        vecs[9]  = '{2'b11, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002};
        vecs[10] = '{2'b10, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[11] = '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
        vecs[12] = '{2'b00, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000};
        vecs[13] = '{2'b00, 32'h0000_0005, 32'h0000_0003, 32'h0000_000F};

        repeat (2) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 1) ? $urandom : 32'($urandom_range(0, 255));
            run_vec($sformatf("rnd%0d", i), ro, ra, rb, ref_mul(ro, ra, rb));
        end

        // start pulsed mid-CALC must be ignored
        launch(2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b00; rs1 = 32'd3; rs2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start", lat, bc);
        total = lat + 5;
        check("ignore_start_result", result, 32'h3FFF_FFFF);
        check("ignore_start_latency", total, exp_lat(2'b01, 32'h7FFF_FFFF));
        @(negedge clk);

        // kill at cycle 10 of CALC: no done, result held
        launch(2'b00, 32'h0000_0007, 32'h8000_0006);
        done_seen = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_no_done", {31'b0, done_seen | done}, 32'd0);
        check("kill_busy", {31'b0, busy}, 32'd0);
        check("kill_result_held", result, 32'h3FFF_FFFF);
        run_vec("after_kill", 2'b00, 32'd3, 32'd3, 32'd9);

        // kill together with start drops the start
        kill = 1'b1; start = 1'b1; op = 2'b00; rs1 = 32'd1; rs2 = 32'd1;
        @(negedge clk);
        kill = 1'b0; start = 1'b0;
        check("kill_start_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("kill_start_busy2", {31'b0, busy | done}, 32'd0);
        check("kill_start_result", result, 32'd9);

        // back-to-back: start during DONE
        launch(2'b00, 32'd7, 32'd6);
        wait_done("b2b_first", lat, bc);
        check("b2b_first_result", result, 32'h0000_002A);
        launch(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("b2b_second", lat, bc);
        check("b2b_second_result", result, 32'hFFFF_FFFE);
        check("b2b_spacing", lat, exp_lat(2'b11, 32'hFFFF_FFFF));
        @(negedge clk);

        // rst mid-CALC
        launch(2'b00, 32'd5, 32'h8000_0000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
